// File: rtl/cnt_checker.sv
// -----------------------------------------------------------------------------
// cnt_checker
//
// Watches the value of an upstream counter. It checks that each valid sample
// moves one step (+1 or -1, mod 256) from the previous one.
//
// The checker has three states:
//   IDLE - waits for the first sample, which seeds the reference value.
//   ACQ  - needs LOCK_CNT consecutive correct steps before it locks.
//   LOCK - flags every mismatching sample. It keeps a flywheel reference so
//          that a single glitch does not shift the expected sequence.
//          MISS_MAX consecutive mismatches drop the lock back to ACQ.
//
// Parameters
//   INC_DEC  : 1 = counter steps +1 per sample, 0 = steps -1 per sample
//   LOCK_CNT : consecutive correct steps needed to lock (1..15)
//   MISS_MAX : consecutive mismatches in LOCK that drop lock (1..15)
//
// Ports
//   clk     in   clock, all logic on the rising edge
//   rst     in   synchronous active-high reset
//   en      in   cnt_in is a valid sample this cycle
//   cnt_in  in   [7:0]  observed counter value
//   clr_err in   synchronous clear of err_cnt (wins over an increment)
//   locked  out  high while in LOCK
//   err     out  one-cycle pulse per mismatching sample while locked
//   err_cnt out  [15:0] saturating mismatch count
//   exp_cnt out  [7:0]  next expected value, prev + step (mod 256)
// -----------------------------------------------------------------------------
module cnt_checker #(
    parameter int INC_DEC  = 1,
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  cnt_in,
    input  logic        clr_err,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_cnt,
    output logic [7:0]  exp_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    // A -1 step is the same as adding 0xFF mod 256, so both wrap cases
    // (255+1 and 0-1) come out naturally from the 8-bit add.
    localparam logic [7:0] STEP       = (INC_DEC != 0) ? 8'h01 : 8'hFF;
    localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_CNT);
    localparam logic [3:0] MISS_LIMIT = 4'(MISS_MAX);

    state_t      state_q, state_d;
    logic [7:0]  prev_q, prev_d;
    logic [3:0]  run_q, run_d;
    logic [3:0]  miss_q, miss_d;
    logic        locked_q, locked_d;
    logic        err_q, err_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [7:0]  exp_val;
    logic        match;
    logic [3:0]  run_inc;
    logic [3:0]  miss_inc;

    assign exp_val  = prev_q + STEP;
    assign match    = (cnt_in == exp_val);
    assign run_inc  = run_q + 4'd1;
    assign miss_inc = miss_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        run_d     = run_q;
        miss_d    = miss_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    prev_d  = cnt_in;
                    run_d   = 4'd0;
                    state_d = ACQ;
                end
            end

            ACQ: begin
                if (en) begin
                    prev_d = cnt_in;
                    if (match) begin
                        if (run_inc == LOCK_LIMIT) begin
                            state_d = LOCK;
                            run_d   = 4'd0;
                            miss_d  = 4'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
            end

            LOCK: begin
                if (en) begin
                    if (match) begin
                        prev_d = cnt_in;
                        miss_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                        if (miss_inc == MISS_LIMIT) begin
                            // Lock lost: restart acquisition from this sample.
                            state_d = ACQ;
                            run_d   = 4'd0;
                            miss_d  = 4'd0;
                            prev_d  = cnt_in;
                        end else begin
                            // Flywheel: advance the reference as if the
                            // sample had been correct.
                            miss_d = miss_inc;
                            prev_d = exp_val;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr_err) begin
            err_cnt_d = 16'd0;
        end

        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= 8'd0;
            run_q     <= 4'd0;
            miss_q    <= 4'd0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            run_q     <= run_d;
            miss_q    <= miss_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign exp_cnt = exp_val;

endmodule

// File: tb/tb_cnt_checker.sv
// -----------------------------------------------------------------------------
// tb_cnt_checker
//
// Directed bench for cnt_checker. It uses two instances:
//   dut_a : INC_DEC=1, LOCK_CNT=4, MISS_MAX=3 (main sequence)
//   dut_b : INC_DEC=0, same thresholds (down-counting wrap case)
//
// Inputs are driven on the falling edge. Outputs are checked on the next
// falling edge, after the rising edge has taken the sample.
// -----------------------------------------------------------------------------
module tb_cnt_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        en_a = 1'b0;
    logic [7:0]  cnt_a = 8'd0;
    logic        clr_a = 1'b0;
    logic        locked_a, err_a;
    logic [15:0] err_cnt_a;
    logic [7:0]  exp_a;

    logic        en_b = 1'b0;
    logic [7:0]  cnt_b = 8'd0;
    logic        clr_b = 1'b0;
    logic        locked_b, err_b;
    logic [15:0] err_cnt_b;
    logic [7:0]  exp_b;

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    cnt_checker #(.INC_DEC(1), .LOCK_CNT(4), .MISS_MAX(3)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .en      (en_a),
        .cnt_in  (cnt_a),
        .clr_err (clr_a),
        .locked  (locked_a),
        .err     (err_a),
        .err_cnt (err_cnt_a),
        .exp_cnt (exp_a)
    );

    cnt_checker #(.INC_DEC(0), .LOCK_CNT(4), .MISS_MAX(3)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .en      (en_b),
        .cnt_in  (cnt_b),
        .clr_err (clr_b),
        .locked  (locked_b),
        .err     (err_b),
        .err_cnt (err_cnt_b),
        .exp_cnt (exp_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        nchecks++;
        assert (obs === expv) else begin
            nerrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Check every dut_a output at once.
    task automatic check_a(input string tag, input logic lk, input logic er,
                           input logic [15:0] ec, input logic [7:0] ex);
        check({tag, ".locked"},  {15'd0, locked_a}, {15'd0, lk});
        check({tag, ".err"},     {15'd0, err_a},    {15'd0, er});
        check({tag, ".err_cnt"}, err_cnt_a,         ec);
        check({tag, ".exp_cnt"}, {8'd0, exp_a},     {8'd0, ex});
        $display("step %-10s locked=%0d err=%0d err_cnt=%04h exp_cnt=%02h",
                 tag, locked_a, err_a, err_cnt_a, exp_a);
    endtask

    // Present one sample to dut_a. The task is called on a falling edge and
    // returns on the next falling edge. en stays as driven, so back-to-back
    // calls give consecutive sample cycles.
    task automatic smp_a(input logic e, input logic [7:0] v, input logic c);
        en_a  = e;
        cnt_a = v;
        clr_a = c;
        @(negedge clk);
    endtask

    task automatic smp_b(input logic e, input logic [7:0] v);
        en_b  = e;
        cnt_b = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check_a("rst", 1'b0, 1'b0, 16'h0000, 8'h01);
        check("rst_b.exp_cnt", {8'd0, exp_b}, 16'h00FF);

        // Initial lock: 10 seeds, then 11..14 are four good steps.
        smp_a(1, 8'd10, 0);  check_a("s10", 0, 0, 16'd0, 8'd11);
        smp_a(1, 8'd11, 0);  check_a("s11", 0, 0, 16'd0, 8'd12);
        smp_a(1, 8'd12, 0);  check_a("s12", 0, 0, 16'd0, 8'd13);
        smp_a(1, 8'd13, 0);  check_a("s13", 0, 0, 16'd0, 8'd14);
        smp_a(1, 8'd14, 0);  check_a("s14", 1, 0, 16'd0, 8'd15);
        smp_a(1, 8'd15, 0);  check_a("s15", 1, 0, 16'd0, 8'd16);

        // A single glitch: 20 arrives where 16 is expected, then 17 resyncs.
        smp_a(1, 8'd20, 0);  check_a("glitch", 1, 1, 16'd1, 8'd17);
        smp_a(1, 8'd17, 0);  check_a("resync", 1, 0, 16'd1, 8'd18);

        // en toggling with correct values.
        smp_a(0, 8'd99, 0);  check_a("en0_1", 1, 0, 16'd1, 8'd18);
        smp_a(1, 8'd18, 0);  check_a("s18", 1, 0, 16'd1, 8'd19);
        smp_a(0, 8'd00, 0);  check_a("en0_2", 1, 0, 16'd1, 8'd19);
        smp_a(1, 8'd19, 0);  check_a("s19", 1, 0, 16'd1, 8'd20);

        // Three consecutive misses drop the lock. The third reseeds from 0.
        smp_a(1, 8'd0, 0);   check_a("miss1", 1, 1, 16'd2, 8'd21);
        smp_a(1, 8'd0, 0);   check_a("miss2", 1, 1, 16'd3, 8'd22);
        smp_a(1, 8'd0, 0);   check_a("miss3", 0, 1, 16'd4, 8'd01);

        // Reacquire. A mismatch in ACQ clears run and raises no error.
        smp_a(1, 8'd1, 0);   check_a("acq1", 0, 0, 16'd4, 8'd2);
        smp_a(1, 8'd2, 0);   check_a("acq2", 0, 0, 16'd4, 8'd3);
        smp_a(1, 8'd9, 0);   check_a("acq_bad", 0, 0, 16'd4, 8'd10);
        smp_a(1, 8'd10, 0);  check_a("acq10", 0, 0, 16'd4, 8'd11);
        smp_a(1, 8'd11, 0);  check_a("acq11", 0, 0, 16'd4, 8'd12);
        smp_a(1, 8'd12, 0);  check_a("acq12", 0, 0, 16'd4, 8'd13);
        smp_a(1, 8'd13, 0);  check_a("relock", 1, 0, 16'd4, 8'd14);

        // One more miss brings err_cnt to 5. Then reset while locked,
        // with en high: the sample is discarded.
        smp_a(1, 8'd99, 0);  check_a("miss5", 1, 1, 16'd5, 8'd15);
        smp_a(1, 8'd15, 0);  check_a("s15b", 1, 0, 16'd5, 8'd16);
        en_a = 1'b1; cnt_a = 8'd16; clr_a = 1'b1;
        do_reset();
        check_a("rst_lock", 0, 0, 16'd0, 8'd01);
        // IDLE after reset: the next sample only seeds, no comparison.
        smp_a(1, 8'd50, 0);  check_a("seed50", 0, 0, 16'd0, 8'd51);

        // Up-count wrap through 0xFF -> 0x00.
        smp_a(1, 8'hF9, 0);  check_a("wF9", 0, 0, 16'd0, 8'hFA);
        smp_a(1, 8'hFA, 0);  check_a("wFA", 0, 0, 16'd0, 8'hFB);
        smp_a(1, 8'hFB, 0);  check_a("wFB", 0, 0, 16'd0, 8'hFC);
        smp_a(1, 8'hFC, 0);  check_a("wFC", 0, 0, 16'd0, 8'hFD);
        smp_a(1, 8'hFD, 0);  check_a("wFD", 1, 0, 16'd0, 8'hFE);
        smp_a(1, 8'hFE, 0);  check_a("wFE", 1, 0, 16'd0, 8'hFF);
        smp_a(1, 8'hFF, 0);  check_a("wFF", 1, 0, 16'd0, 8'h00);
        smp_a(1, 8'h00, 0);  check_a("w00", 1, 0, 16'd0, 8'h01);
        smp_a(1, 8'h01, 0);  check_a("w01", 1, 0, 16'd0, 8'h02);

        // clr_err on the same cycle as a mismatch: the clear wins and err
        // still pulses.
        smp_a(1, 8'h77, 0);  check_a("pre_clr", 1, 1, 16'd1, 8'h03);
        smp_a(1, 8'h03, 0);  check_a("s03", 1, 0, 16'd1, 8'h04);
        smp_a(1, 8'h77, 1);  check_a("clr_miss", 1, 1, 16'd0, 8'h05);
        smp_a(1, 8'h05, 0);  check_a("s05", 1, 0, 16'd0, 8'h06);

        // Saturation: preload the counter one below the maximum.
        force dut_a.err_cnt_q = 16'hFFFE;
        #1;
        release dut_a.err_cnt_q;
        smp_a(1, 8'h88, 0);  check_a("sat1", 1, 1, 16'hFFFF, 8'h07);
        smp_a(1, 8'h07, 0);  check_a("s07", 1, 0, 16'hFFFF, 8'h08);
        smp_a(1, 8'h88, 0);  check_a("sat2", 1, 1, 16'hFFFF, 8'h09);

        // clr_err alone, with no sample.
        smp_a(0, 8'h00, 1);  check_a("clr_only", 1, 0, 16'd0, 8'h09);
        clr_a = 1'b0;

        // Down-count variant wraps 0x00 -> 0xFF.
        smp_b(1, 8'h07);
        smp_b(1, 8'h06);
        smp_b(1, 8'h05);
        smp_b(1, 8'h04);
        check("b_pre.locked", {15'd0, locked_b}, 16'd0);
        smp_b(1, 8'h03);
        check("b_lock.locked", {15'd0, locked_b}, 16'd1);
        check("b_lock.exp_cnt", {8'd0, exp_b}, 16'h0002);
        smp_b(1, 8'h02);
        smp_b(1, 8'h01);
        smp_b(1, 8'h00);
        check("b00.exp_cnt", {8'd0, exp_b}, 16'h00FF);
        smp_b(1, 8'hFF);
        smp_b(0, 8'h00);
        check("bFF.locked", {15'd0, locked_b}, 16'd1);
        check("bFF.err", {15'd0, err_b}, 16'd0);
        check("bFF.err_cnt", err_cnt_b, 16'd0);
        check("bFF.exp_cnt", {8'd0, exp_b}, 16'h00FE);
        $display("step %-10s locked=%0d err=%0d err_cnt=%04h exp_cnt=%02h",
                 "b_wrap", locked_b, err_b, err_cnt_b, exp_b);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/cnt_checker.md
CNT_CHECKER -- requirements
Module: cnt_checker

Interface
REQ-001 Parameter INC_DEC, default 1, expected step direction: 1 = +1 per sample, 0 = -1 per sample.
REQ-002 Parameter LOCK_CNT, default 4, range 1..15, consecutive correct steps required to lock.
REQ-003 Parameter MISS_MAX, default 3, range 1..15, consecutive mismatches that drop lock.
REQ-004 Port clk  input  1  single clock; all logic on posedge clk.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port en  input  1  cnt_in valid this cycle; only en=1 cycles are samples.
REQ-007 Port cnt_in  input  8  observed count from the upstream counter.
REQ-008 Port clr_err  input  1  synchronous clear of err_cnt.
REQ-009 Port locked  output  1  high while in LOCK state.
REQ-010 Port err  output  1  one-cycle pulse per mismatching sample in LOCK.
REQ-011 Port err_cnt  output  16  saturating count of mismatches.
REQ-012 Port exp_cnt  output  8  next expected value, (prev + step) mod 256.

Function
REQ-013 The block SHALL implement states IDLE, ACQ and LOCK, all outputs registered.
REQ-014 The step SHALL be +1 when INC_DEC=1 and -1 otherwise, computed mod 256 (255+1 -> 0, 0-1 -> 255, never a mismatch at wrap).
REQ-015 With en=0 the block SHALL hold state, prev, run and miss, and drive err=0.
REQ-016 IDLE, en=1: SHALL latch prev<=cnt_in, clear run, go to ACQ; no comparison.
REQ-017 ACQ, en=1, cnt_in==exp_cnt: SHALL increment run; when run reaches LOCK_CNT, go to LOCK, clear miss.
REQ-018 ACQ, en=1, cnt_in!=exp_cnt: SHALL clear run and stay in ACQ; err SHALL stay 0, err_cnt unchanged.
REQ-019 In IDLE and ACQ, every sample SHALL load prev<=cnt_in.
REQ-020 LOCK, en=1, match: SHALL load prev<=cnt_in, clear miss, err=0.
REQ-021 LOCK, en=1, mismatch: SHALL load prev<=exp_cnt (flywheel), pulse err=1 next cycle, increment err_cnt, increment miss.
REQ-022 When miss reaches MISS_MAX, the block SHALL go to ACQ with run=0, prev<=cnt_in, and locked=0 from the next cycle.
REQ-023 locked SHALL rise in the cycle after the sample that completes LOCK_CNT matches and fall in the cycle after the MISS_MAX-th mismatch.
REQ-024 err_cnt SHALL saturate at 16'hFFFF; further mismatches still pulse err.
REQ-025 clr_err=1 SHALL set err_cnt to 0; clr_err coinciding with a mismatch SHALL yield err_cnt=0 (clear wins), err still pulses.
REQ-026 exp_cnt SHALL always equal (prev + step) mod 256 combinationally from the registered prev, registered form acceptable if identical per cycle.

Reset
REQ-027 rst=1 at a clock edge SHALL force state=IDLE, prev=0, run=0, miss=0, locked=0, err=0, err_cnt=0, exp_cnt=step applied to 0 (1 or 255).
REQ-028 rst SHALL override en and clr_err; reset mid-LOCK SHALL drop locked on the next cycle and discard the current sample.

Verification
REQ-029 INC_DEC=1, LOCK_CNT=4: samples 10,11,12,13,14 on consecutive en cycles -> locked=1 the cycle after 14, err never set, err_cnt=0.
REQ-030 Locked at 0xFD, samples FE,FF,00,01 -> no err, locked stays 1 (wrap). INC_DEC=0 variant: 02,01,00,FF -> same.
REQ-031 Locked, sample 20 where 16 expected, then 17 -> one err pulse, err_cnt=1, miss cleared, locked stays 1.
REQ-032 MISS_MAX=3, locked, three consecutive wrong samples -> three err pulses, err_cnt=3, locked=0 after third, state ACQ; four good steps relock.
REQ-033 en toggling 1/0 during lock with correct values -> no err; clr_err with simultaneous mismatch -> err_cnt=0, err=1.
REQ-034 rst asserted for one cycle while locked with err_cnt=5 -> next cycle locked=0, err_cnt=0, err=0, IDLE; err_cnt forced to FFFF stays FFFF on further mismatch.
